// File: rtl/arvi_bus_pkg.sv
// Shared definitions for the multi-master bus arbiter: FSM state encoding
// and the width helpers that derive byte-enable and timeout-counter sizes
// from the module parameters.
package arvi_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2,
        ST_HOLD = 2'd3
    } arb_state_t;

    // One byte-enable bit per byte of the data word.
    function automatic int be_width(input int xlen);
        return xlen / 8;
    endfunction

    // Counter wide enough to hold 0..timeout; a disabled timeout (0) still
    // gets a 1-bit counter so the register never collapses to zero width.
    function automatic int cnt_width(input int timeout);
        if (timeout < 1) begin
            return 1;
        end
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: returns the first eligible requester
// strictly after the pointer, wrapping, so the pointer position itself has
// the lowest priority. Eligibility is req AND mask.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic [N-1:0]  mask,
    output logic          valid,
    output logic [IW-1:0] grant_idx,
    output logic [N-1:0]  grant_oh
);

    logic [N-1:0] eligible;

    assign eligible = req & mask;

    // Scan the N positions following the pointer and keep the first hit.
    always_comb begin
        valid     = 1'b0;
        grant_idx = '0;
        grant_oh  = '0;
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (int'(ptr) + k) % N;
            if (!valid && eligible[idx]) begin
                valid         = 1'b1;
                grant_idx     = IW'(idx);
                grant_oh[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// N-master, single-slave bus arbiter. Grants one master at a time in
// round-robin order, drives the shared bus from registered copies of the
// winner's request, supports a lock hold for atomic sequences and an ack
// timeout that completes the transaction with an error.
//
// state | meaning
// IDLE  | no owner; arbitrate among all requesters
// BUSY  | bus transaction in flight, waiting for i_ack or timeout
// DONE  | one-cycle o_ready/o_err pulse, no arbitration
// HOLD  | locked owner keeps the grant; only it may issue
module bus_arbiter
    import arvi_bus_pkg::*;
#(
    parameter int N_MASTERS = 4,
    parameter int XLEN      = 32,
    parameter int TIMEOUT   = 255
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [N_MASTERS-1:0]          i_req,
    input  logic [N_MASTERS-1:0]          i_wr_en,
    input  logic [N_MASTERS-1:0]          i_lock,
    input  logic [N_MASTERS*XLEN-1:0]     i_addr,
    input  logic [N_MASTERS*XLEN-1:0]     i_wr_data,
    input  logic [N_MASTERS*XLEN/8-1:0]   i_byte_en,
    output logic [N_MASTERS-1:0]          o_ready,
    output logic [N_MASTERS-1:0]          o_err,
    output logic [XLEN-1:0]               o_rd_data,
    output logic [N_MASTERS-1:0]          o_grant,
    input  logic                          i_ack,
    input  logic [XLEN-1:0]               i_rd_data,
    output logic                          o_bus_en,
    output logic                          o_wr_en,
    output logic [XLEN-1:0]               o_addr,
    output logic [XLEN-1:0]               o_wr_data,
    output logic [XLEN/8-1:0]             o_byte_en
);

    localparam int BW      = be_width(XLEN);
    localparam int CW      = cnt_width(TIMEOUT);
    localparam int IW      = $clog2(N_MASTERS);
    localparam bit TO_EN   = (TIMEOUT != 0);
    localparam int TO_LASTI = TO_EN ? (TIMEOUT - 1) : 0;
    localparam logic [CW-1:0] TO_LAST = CW'(TO_LASTI);

    arb_state_t state, state_nxt;

    logic [IW-1:0]        ptr, ptr_nxt;
    logic [CW-1:0]        cnt, cnt_nxt;
    logic                 timed_out, timed_out_nxt;
    logic [N_MASTERS-1:0] grant_nxt;
    logic [N_MASTERS-1:0] ready_nxt;
    logic [N_MASTERS-1:0] err_nxt;
    logic [XLEN-1:0]      rd_data_nxt;
    logic                 bus_en_nxt;
    logic                 wr_en_nxt;
    logic [XLEN-1:0]      addr_nxt;
    logic [XLEN-1:0]      wr_data_nxt;
    logic [BW-1:0]        byte_en_nxt;

    logic                 arb_valid;
    logic [IW-1:0]        arb_idx;
    logic [N_MASTERS-1:0] arb_oh;
    logic [N_MASTERS-1:0] arb_mask;

    logic                 sel_wr_en;
    logic [XLEN-1:0]      sel_addr;
    logic [XLEN-1:0]      sel_wr_data;
    logic [BW-1:0]        sel_byte_en;
    logic                 owner_lock;
    logic                 timeout_hit;

    // In HOLD only the current owner is eligible; the pointer already sits
    // on the owner, so the wrap-around scan lands back on it.
    assign arb_mask    = (state == ST_HOLD) ? o_grant : '1;
    assign owner_lock  = |(i_lock & o_grant);
    assign timeout_hit = TO_EN && (cnt == TO_LAST);

    rr_arbiter #(
        .N  (N_MASTERS),
        .IW (IW)
    ) u_rr (
        .req       (i_req),
        .ptr       (ptr),
        .mask      (arb_mask),
        .valid     (arb_valid),
        .grant_idx (arb_idx),
        .grant_oh  (arb_oh)
    );

    // Mux the winning master's request fields out of the packed inputs.
    always_comb begin
        sel_wr_en   = 1'b0;
        sel_addr    = '0;
        sel_wr_data = '0;
        sel_byte_en = '0;
        for (int m = 0; m < N_MASTERS; m++) begin
            if (arb_oh[m]) begin
                sel_wr_en   = i_wr_en[m];
                sel_addr    = i_addr[m*XLEN +: XLEN];
                sel_wr_data = i_wr_data[m*XLEN +: XLEN];
                sel_byte_en = i_byte_en[m*BW +: BW];
            end
        end
    end

    // Next-state and next-output logic; every output register holds its
    // value unless a transition below changes it, except the pulses.
    always_comb begin
        state_nxt     = state;
        ptr_nxt       = ptr;
        cnt_nxt       = cnt;
        timed_out_nxt = timed_out;
        grant_nxt     = o_grant;
        ready_nxt     = '0;
        err_nxt       = '0;
        rd_data_nxt   = o_rd_data;
        bus_en_nxt    = o_bus_en;
        wr_en_nxt     = o_wr_en;
        addr_nxt      = o_addr;
        wr_data_nxt   = o_wr_data;
        byte_en_nxt   = o_byte_en;

        unique case (state)
            ST_IDLE, ST_HOLD: begin
                if (arb_valid) begin
                    ptr_nxt       = arb_idx;
                    grant_nxt     = arb_oh;
                    bus_en_nxt    = 1'b1;
                    wr_en_nxt     = sel_wr_en;
                    addr_nxt      = sel_addr;
                    wr_data_nxt   = sel_wr_data;
                    byte_en_nxt   = sel_byte_en;
                    cnt_nxt       = '0;
                    timed_out_nxt = 1'b0;
                    state_nxt     = ST_BUSY;
                end else if (state == ST_HOLD && !owner_lock) begin
                    grant_nxt = '0;
                    state_nxt = ST_IDLE;
                end
            end

            ST_BUSY: begin
                // An ack arriving in the timeout cycle still counts as success.
                if (i_ack) begin
                    bus_en_nxt  = 1'b0;
                    ready_nxt   = o_grant;
                    rd_data_nxt = i_rd_data;
                    state_nxt   = ST_DONE;
                end else if (timeout_hit) begin
                    bus_en_nxt    = 1'b0;
                    ready_nxt     = o_grant;
                    err_nxt       = o_grant;
                    rd_data_nxt   = '0;
                    timed_out_nxt = 1'b1;
                    state_nxt     = ST_DONE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            ST_DONE: begin
                // A timed-out sequence gives up its lock.
                if (owner_lock && !timed_out) begin
                    state_nxt = ST_HOLD;
                end else begin
                    grant_nxt = '0;
                    state_nxt = ST_IDLE;
                end
            end

            default: begin
                grant_nxt  = '0;
                bus_en_nxt = 1'b0;
                state_nxt  = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= ST_IDLE;
            ptr       <= IW'(N_MASTERS - 1);
            cnt       <= '0;
            timed_out <= 1'b0;
            o_grant   <= '0;
            o_ready   <= '0;
            o_err     <= '0;
            o_rd_data <= '0;
            o_bus_en  <= 1'b0;
            o_wr_en   <= 1'b0;
            o_addr    <= '0;
            o_wr_data <= '0;
            o_byte_en <= '0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            cnt       <= cnt_nxt;
            timed_out <= timed_out_nxt;
            o_grant   <= grant_nxt;
            o_ready   <= ready_nxt;
            o_err     <= err_nxt;
            o_rd_data <= rd_data_nxt;
            o_bus_en  <= bus_en_nxt;
            o_wr_en   <= wr_en_nxt;
            o_addr    <= addr_nxt;
            o_wr_data <= wr_data_nxt;
            o_byte_en <= byte_en_nxt;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: transaction queues per master, a
// reacting slave, and a transaction-level reference model of the
// round-robin / lock / timeout rules.
module tb_bus_arbiter;

    localparam int N  = 4;
    localparam int XW = 32;
    localparam int TO = 8;

    logic              i_clk = 1'b0;
    logic              i_rst;
    logic [N-1:0]      i_req, i_wr_en, i_lock;
    logic [N*XW-1:0]   i_addr, i_wr_data;
    logic [N*XW/8-1:0] i_byte_en;
    logic [N-1:0]      o_ready, o_err, o_grant;
    logic [XW-1:0]     o_rd_data;
    logic              i_ack;
    logic [XW-1:0]     i_rd_data;
    logic              o_bus_en, o_wr_en;
    logic [XW-1:0]     o_addr, o_wr_data;
    logic [XW/8-1:0]   o_byte_en;

    always #5 i_clk = ~i_clk;

    bus_arbiter #(.N_MASTERS(N), .XLEN(XW), .TIMEOUT(TO)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .i_wr_en(i_wr_en),
        .i_lock(i_lock), .i_addr(i_addr), .i_wr_data(i_wr_data),
        .i_byte_en(i_byte_en), .o_ready(o_ready), .o_err(o_err),
        .o_rd_data(o_rd_data), .o_grant(o_grant), .i_ack(i_ack),
        .i_rd_data(i_rd_data), .o_bus_en(o_bus_en), .o_wr_en(o_wr_en),
        .o_addr(o_addr), .o_wr_data(o_wr_data), .o_byte_en(o_byte_en)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] rd;
        logic [3:0]  be;
        logic        lock;   // keep the grant after this transaction
        int          ack_at; // bus_en cycle in which the slave acks, 0 = never
        int          gap;    // idle cycles before the next request
    } txn_t;

    txn_t tq[N][32];
    int   hd[N], tl[N], gap[N];
    logic prev_lock[N], done_now[N];

    int   active, busy_cnt, last, hold, free_tick, done_pend, done_owner;
    logic done_err;
    int   tk, run, rcnt, gcnt;
    int   glog[128], rlog[128];
    int   n_cmp, n_bad;

    logic [N-1:0]  r_req, r_lock;
    logic          r_ack, r_rst;
    logic [XW-1:0] r_rdd;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h (tick %0d)", tag, obs, want, tk);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] r, input int lst);
        for (int k = 1; k <= N; k++) begin
            if (r[(lst + k) % N]) return (lst + k) % N;
        end
        return -1;
    endfunction

    function automatic logic all_empty();
        for (int m = 0; m < N; m++) if (hd[m] < tl[m]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic enq(input int m, input logic wr, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] be, input logic lock,
                       input int ack_at, input int g, input logic [31:0] rd);
        tq[m][tl[m]] = '{wr, addr, data, rd, be, lock, ack_at, g};
        tl[m]++;
    endtask

    // Reference model: evaluated once per clock, after the edge.
    task automatic model_eval();
        txn_t t;
        int   w;
        logic e;
        if (r_rst) begin
            chk("rst_bus_en", o_bus_en, 0);
            chk("rst_ready", o_ready, 0);
            chk("rst_err", o_err, 0);
            chk("rst_grant", o_grant, 0);
            active = -1; hold = -1; last = N - 1; done_pend = 0; free_tick = tk + 1;
        end else if (active >= 0) begin
            t = tq[active][hd[active]];
            if (r_ack || busy_cnt == TO) begin
                e = !r_ack;
                chk("ready", o_ready, 1 << active);
                chk("err", o_err, e ? (1 << active) : 0);
                chk("rd_data", o_rd_data, e ? 32'h0 : r_rdd);
                chk("bus_en_off", o_bus_en, 0);
                done_err = e; done_owner = active; done_pend = 1; free_tick = tk + 2;
                prev_lock[active] = t.lock; gap[active] = t.gap; done_now[active] = 1'b1;
                hd[active]++;
                active = -1;
            end else begin
                chk("bus_held", o_bus_en, 1);
                chk("no_ready", o_ready, 0);
                chk("addr_stable", o_addr, t.addr);
                chk("grant_stable", o_grant, 1 << active);
                busy_cnt++;
            end
        end else begin
            w = -1;
            if (done_pend != 0) begin
                done_pend = 0;
                hold = (r_lock[done_owner] && !done_err) ? done_owner : -1;
                chk("grant_after_done", o_grant, (hold >= 0) ? (1 << done_owner) : 0);
            end else if (tk >= free_tick) begin
                if (hold >= 0) begin
                    if (r_req[hold]) w = hold;
                    else if (!r_lock[hold]) begin
                        hold = -1; free_tick = tk + 1;
                        chk("grant_release", o_grant, 0);
                    end
                end else begin
                    w = rr_pick(r_req, last);
                end
            end
            chk("bus_start", o_bus_en, w >= 0);
            chk("idle_ready", o_ready, 0);
            if (w >= 0) begin
                t = tq[w][hd[w]];
                chk("grant", o_grant, 1 << w);
                chk("wr_en", o_wr_en, t.wr);
                chk("addr", o_addr, t.addr);
                chk("wr_data", o_wr_data, t.data);
                chk("byte_en", o_byte_en, t.be);
                active = w; busy_cnt = 1; last = w; hold = -1;
                if (gcnt < 128) begin glog[gcnt] = w; gcnt++; end
            end
        end
    endtask

    // Master and slave behaviour for the coming cycle.
    task automatic drive_update();
        txn_t t;
        for (int m = 0; m < N; m++) begin
            if (done_now[m]) begin
                i_req[m] = 1'b0; done_now[m] = 1'b0;
            end else if (gap[m] > 0) begin
                i_req[m] = 1'b0; gap[m]--;
            end else begin
                i_req[m] = (hd[m] < tl[m]);
            end
            if (i_req[m]) begin
                t = tq[m][hd[m]];
                i_wr_en[m] = t.wr;
                i_addr[m*XW +: XW] = t.addr;
                i_wr_data[m*XW +: XW] = t.data;
                i_byte_en[m*4 +: 4] = t.be;
            end else begin
                i_wr_en[m] = $urandom_range(0, 1) == 1;
                i_addr[m*XW +: XW] = $urandom;
                i_wr_data[m*XW +: XW] = $urandom;
                i_byte_en[m*4 +: 4] = 4'($urandom);
            end
            i_lock[m] = (hd[m] < tl[m]) && (prev_lock[m] || tq[m][hd[m]].lock);
        end
        if (active >= 0) begin
            t = tq[active][hd[active]];
            i_ack = (busy_cnt == t.ack_at);
            i_rd_data = i_ack ? t.rd : $urandom;
        end else begin
            i_ack = ($urandom_range(0, 3) == 0);
            i_rd_data = $urandom;
        end
    endtask

    task automatic tick();
        r_req = i_req; r_lock = i_lock; r_ack = i_ack; r_rdd = i_rd_data; r_rst = i_rst;
        @(posedge i_clk);
        #1;
        tk++;
        if (o_bus_en) run++;
        else if (run > 0) begin
            if (rcnt < 128) begin rlog[rcnt] = run; rcnt++; end
            run = 0;
        end
        model_eval();
        drive_update();
    endtask

    task automatic run_all(input int budget);
        int c;
        c = 0;
        while (!(all_empty() && active < 0 && done_pend == 0) && c < budget) begin
            tick(); c++;
        end
        chk("drain_budget", c < budget, 1);
        tick(); tick();
    endtask

    int gs, rs, c;

    initial begin
        n_cmp = 0; n_bad = 0; tk = 0; run = 0; rcnt = 0; gcnt = 0;
        active = -1; hold = -1; last = N - 1; done_pend = 0; free_tick = 0; busy_cnt = 0;
        done_err = 0; done_owner = 0;
        for (int m = 0; m < N; m++) begin
            hd[m] = 0; tl[m] = 0; gap[m] = 0; prev_lock[m] = 0; done_now[m] = 0;
        end
        i_rst = 1'b1; i_req = '0; i_wr_en = '0; i_lock = '0; i_addr = '0;
        i_wr_data = '0; i_byte_en = '0; i_ack = 1'b0; i_rd_data = '0;
        tick(); tick(); tick();
        i_rst = 1'b0;

        // All four masters back-to-back, ack one cycle after bus_en.
        gs = gcnt;
        for (int k = 0; k < 2; k++)
            for (int m = 0; m < N; m++)
                enq(m, k[0], 32'h1000 + 32'(m * 16 + k), $urandom, 4'hF, 1'b0, 2, 0, $urandom);
        run_all(200);
        for (int i = 0; i < 8; i++) chk("rr_order", glog[gs + i], i % N);

        // Master 0 read, ack two cycles after bus_en rises.
        rs = rcnt;
        enq(0, 1'b0, 32'h100, 32'h0, 4'hF, 1'b0, 3, 0, 32'hDEADBEEF);
        run_all(40);
        chk("t1_bus_en_cycles", rlog[rs], 3);
        chk("t1_rd_data", o_rd_data, 32'hDEADBEEF);

        // Locked pair of writes by master 1, master 2 competing.
        gs = gcnt;
        enq(1, 1'b1, 32'h200, 32'h1, 4'hF, 1'b1, 1, 2, 32'h0);
        enq(1, 1'b1, 32'h200, 32'h2, 4'hF, 1'b0, 1, 0, 32'h0);
        enq(2, 1'b0, 32'h300, 32'h0, 4'hF, 1'b0, 1, 0, 32'h77);
        run_all(80);
        chk("lock_order0", glog[gs], 1);
        chk("lock_order1", glog[gs + 1], 1);
        chk("lock_order2", glog[gs + 2], 2);

        // Master 3 times out while holding a lock; master 0 then wins.
        gs = gcnt; rs = rcnt;
        enq(3, 1'b0, 32'h400, 32'h0, 4'hF, 1'b1, 0, 1, 32'h0);
        enq(3, 1'b0, 32'h404, 32'h0, 4'hF, 1'b0, 1, 0, 32'h9);
        enq(0, 1'b0, 32'h408, 32'h0, 4'hF, 1'b0, 1, 0, 32'hA);
        run_all(80);
        chk("to_bus_en_cycles", rlog[rs], TO);
        chk("to_order0", glog[gs], 3);
        chk("to_order1", glog[gs + 1], 0);
        chk("to_order2", glog[gs + 2], 3);

        // Ack in the very cycle the timeout would fire.
        rs = rcnt;
        enq(0, 1'b0, 32'h500, 32'h0, 4'hF, 1'b0, TO, 0, 32'h55);
        run_all(40);
        chk("late_ack_cycles", rlog[rs], TO);
        chk("late_ack_rd", o_rd_data, 32'h55);
        chk("late_ack_err", o_err, 0);

        // Reset while master 2 is on the bus; master 0 wins afterwards.
        enq(2, 1'b0, 32'h600, 32'h0, 4'hF, 1'b0, 5, 0, 32'h66);
        enq(0, 1'b0, 32'h604, 32'h0, 4'hF, 1'b0, 1, 0, 32'h60);
        c = 0;
        while (!(active == 2 && busy_cnt == 2) && c < 40) begin tick(); c++; end
        chk("reach_busy_m2", c < 40, 1);
        i_rst = 1'b1; i_ack = 1'b0;
        tick();
        i_rst = 1'b0;
        gs = gcnt;
        run_all(60);
        chk("post_rst_order0", glog[gs], 0);
        chk("post_rst_order1", glog[gs + 1], 2);

        // Randomised traffic against the model.
        for (int m = 0; m < N; m++)
            for (int k = 0; k < 8; k++)
                enq(m, $urandom_range(0, 1) == 1, $urandom, $urandom, 4'($urandom),
                    $urandom_range(0, 4) == 0,
                    ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, TO),
                    $urandom_range(0, 3), $urandom);
        run_all(3000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Parametrised N-master, single-slave bus arbiter. It generalises the current one-hart instruction/data bus bridge to multi-hart SoCs.
- Each master port carries a request/ready handshake: one hart IM or DM port, already narrowed to word access by the hart-side logic.
- The arbiter grants one master at a time in round-robin order and drives the shared `BUS_M` interface (o_bus_en/o_wr_en/o_addr/o_wr_data/o_byte_en, i_ack/i_rd_data).
- Adds an atomic lock hold for AMO/LR-SC sequences and an ack timeout with error return.

Parameters:
- N_MASTERS, 4, number of master ports (2..16).
- XLEN, 32, address/data width.
- TIMEOUT, 255, cycles to wait for i_ack before error completion; 0 disables the timeout.

Ports:
- i_clk  in  1  clock, rising edge
- i_rst  in  1  synchronous, active-high reset
- i_req  in  N_MASTERS  per-master request, held until o_ready
- i_wr_en  in  N_MASTERS  per-master write (1) / read (0)
- i_lock  in  N_MASTERS  per-master keep-grant request (atomic sequence)
- i_addr  in  N_MASTERS*XLEN  packed addresses, master m at [m*XLEN +: XLEN]
- i_wr_data  in  N_MASTERS*XLEN  packed write data
- i_byte_en  in  N_MASTERS*XLEN/8  packed byte enables
- o_ready  out  N_MASTERS  one-cycle completion pulse
- o_err  out  N_MASTERS  one-cycle error pulse, coincident with o_ready (timeout)
- o_rd_data  out  XLEN  shared read data, valid when any o_ready is high
- o_grant  out  N_MASTERS  one-hot current owner, 0 when idle
- i_ack  in  1  slave completion
- i_rd_data  in  XLEN  slave read data
- o_bus_en  out  1  bus transaction active
- o_wr_en  out  1  write strobe
- o_addr  out  XLEN  address
- o_wr_data  out  XLEN  write data
- o_byte_en  out  XLEN/8  byte enables

Behaviour:
- All outputs are registered.
- Reset: state=IDLE, every output 0, counter 0, rr pointer=N_MASTERS-1, so master 0 wins first.

States:
- IDLE:
  - If any i_req: pick the first requester after the rr pointer (wrapping).
  - Latch that master's wr_en/addr/wr_data/byte_en into the bus output registers.
  - Set o_grant; o_bus_en=1 next cycle; go to BUSY. Pointer := winner.
- BUSY:
  - o_bus_en and all bus outputs held stable; timeout counter increments each cycle.
  - On i_ack: o_bus_en=0; o_ready[g]=1; o_rd_data=i_rd_data (captured for writes too); go to DONE.
  - If counter reaches TIMEOUT without ack: o_bus_en=0; o_ready[g]=o_err[g]=1; o_rd_data=0; lock discarded; go to DONE.
  - Ack in the timeout cycle wins: normal completion, no error.
- DONE (1 cycle): o_ready/o_err pulse visible; no arbitration this cycle (the master drops i_req here).
  - If i_lock[g]=1 and no timeout occurred: go to HOLD.
  - Otherwise: o_grant=0; go to IDLE.
- HOLD:
  - Only master g is eligible; other requests wait.
  - If i_req[g]: issue as in IDLE (pointer unchanged); go to BUSY.
  - Else if i_lock[g]=0: o_grant=0; go to IDLE.

Timing and protocol rules:
- Minimum transaction: request sampled in cycle t, o_bus_en in t+1, ack at earliest t+1, o_ready at t+2.
- The next grant is sampled no earlier than t+3.
- i_ack outside BUSY is ignored.
- A master dropping i_req during BUSY is a protocol violation; the transaction still completes and ready still pulses.
- Request inputs of non-granted masters never affect bus outputs.
- i_rst asserted mid-BUSY: next cycle o_bus_en=0 with no o_ready, and the pointer resets.

Decomposition:
- Shared package arvi_bus_pkg: state encoding (IDLE/BUSY/DONE/HOLD), byte-enable width function XLEN/8, timeout counter width $clog2(TIMEOUT+1).
- Sub-module rr_arbiter: pure combinational round-robin one-hot picker (req vector, pointer, mask) → grant index/one-hot. Unit-tested standalone.

Test Plan:
- Master 0 read: addr=0x100; i_ack two cycles after o_bus_en rises, i_rd_data=0xDEADBEEF → o_bus_en high 3 cycles, o_ready[0] pulse next cycle with o_rd_data=0xDEADBEEF, o_err=0.
- All 4 masters requesting continuously, ack 1 cycle after bus_en → grant order 0,1,2,3,0; each o_ready exactly once per grant.
- Master 1: i_lock=1 and two writes to 0x200 (byte_en=0xF, data 0x1, 0x2), master 2 requesting throughout → both master 1 writes issue back-to-back; master 2 is granted only after i_lock[1] drops.
- TIMEOUT=8, master 3 read, no ack → o_bus_en high 8 cycles, then o_ready[3]=o_err[3]=1, o_rd_data=0; held lock released.
- TIMEOUT=8, i_ack exactly on cycle 8 with i_rd_data=0x55 → o_ready with o_err=0, o_rd_data=0x55.
- i_rst pulsed during BUSY for master 2 → o_bus_en=0 next cycle, no o_ready; after reset, masters 0 and 2 request → master 0 granted first.
